// File: rtl/arb_pkg.sv
// Shared definitions for the 4-channel packet round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int ARB_N     = 4;
    localparam int ARB_WIDTH = 33;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid channel after i_last, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N
) (
    input  logic [N-1:0]         i_valid,
    input  logic [$clog2(N)-1:0] i_last,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_id,
    output logic                 o_any
);

    localparam int IDW = $clog2(N);

    int w_idx;

    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        // Scan last+1 .. last+N so the previous winner ends up lowest priority.
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(i_last) + k) % N;
            if (!o_any && i_valid[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_id           = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4ch.sv
// Packet-granular round-robin arbiter: N flit inputs merged into one registered output.
module rr_arbiter_4ch
    import arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int WIDTH = ARB_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N-1:0]                in_valid,
    input  logic [N-1:0][WIDTH-1:0]     in_data,
    input  logic [N-1:0]                in_tail,
    output logic [N-1:0]                in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_tail,
    output logic [$clog2(N)-1:0]        out_id,
    input  logic                        out_ready,
    output logic [15:0]                 pkt_count
);

    localparam int IDW = $clog2(N);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [IDW-1:0]   r_lock_id;
    logic [IDW-1:0]   r_last;

    logic [N-1:0]     w_pick_valid;
    logic [N-1:0]     w_grant;
    logic [IDW-1:0]   w_id;
    logic             w_any;
    logic             w_load;
    logic             w_xfer;
    logic             w_sel_tail;
    logic [WIDTH-1:0] w_sel_data;

    // While locked, only the owner may be picked; picker then sees at most one bit.
    assign w_pick_valid = (r_state == LOCKED) ? (in_valid & (N'(1) << r_lock_id))
                                              : in_valid;

    rr_pick #(
        .N (N)
    ) u_pick (
        .i_valid (w_pick_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_id    (w_id),
        .o_any   (w_any)
    );

    assign w_load     = !out_valid || out_ready;
    assign in_ready   = (rst_n && w_load) ? w_grant : '0;
    assign w_xfer     = rst_n && w_load && w_any;
    assign w_sel_tail = in_tail[w_id];
    assign w_sel_data = in_data[w_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer && !w_sel_tail) begin
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (w_xfer && w_sel_tail) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Fairness pointer moves only at packet boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_id <= '0;
            r_last    <= IDW'(N - 1);
        end else if (w_xfer) begin
            if (r_state == IDLE && !w_sel_tail) begin
                r_lock_id <= w_id;
            end
            if (w_sel_tail) begin
                r_last <= w_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tail  <= 1'b0;
            out_id    <= '0;
        end else if (w_load) begin
            out_valid <= w_xfer;
            if (w_xfer) begin
                out_data <= w_sel_data;
                out_tail <= w_sel_tail;
                out_id   <= w_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
        end else if (out_valid && out_ready && out_tail) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// Directed bench for rr_arbiter_4ch: ordering, locking, backpressure, wrap, reset.
module tb_rr_arbiter_4ch;

    localparam int N     = 4;
    localparam int WIDTH = 33;

    logic                    clk;
    logic                    rst_n;
    logic [N-1:0]            in_valid;
    logic [N-1:0][WIDTH-1:0] in_data;
    logic [N-1:0]            in_tail;
    logic [N-1:0]            in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic                    out_tail;
    logic [1:0]              out_id;
    logic                    out_ready;
    logic [15:0]             pkt_count;

    int n_checks;
    int n_fail;

    rr_arbiter_4ch #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tail   (in_tail),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tail  (out_tail),
        .out_id    (out_id),
        .out_ready (out_ready),
        .pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid  = '0;
        in_data   = '0;
        in_tail   = '0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        in_valid = 4'b1111;
        in_tail  = 4'b1111;
        #2;
        n_checks++;
        if (in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_tail !== 1'b0 || out_id !== 2'd0) begin
            n_fail++; $display("FAIL reset_out_ctl: got v=%b t=%b id=%0d want 0 0 0", out_valid, out_tail, out_id);
        end
        n_checks++;
        if (out_data !== 33'd0 || pkt_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_data_cnt: got data=%h cnt=%0d want 0 0", out_data, pkt_count);
        end
        step();
    endtask

    task automatic test_rr_order();
        do_reset();
        in_valid = 4'b1111;
        in_tail  = 4'b1111;
        for (int i = 0; i < N; i++) in_data[i] = 33'h0A + 33'(i);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_no_early_valid: got %b want 0", out_valid);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (in_ready !== 4'(1 << (k % 4))) begin
                n_fail++; $display("FAIL rr_ready_%0d: got %b want %b", k, in_ready, 4'(1 << (k % 4)));
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== 2'(k % 4) || out_data !== 33'h0A + 33'(k % 4) || out_tail !== 1'b1) begin
                n_fail++; $display("FAIL rr_out_%0d: got v=%b id=%0d data=%h want 1 %0d %h", k, out_valid, out_id, out_data, k % 4, 33'h0A + 33'(k % 4));
            end
        end
        in_valid = '0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || pkt_count !== 16'd8) begin
            n_fail++; $display("FAIL rr_drain: got v=%b cnt=%0d want 0 8", out_valid, pkt_count);
        end
    endtask

    task automatic test_locked();
        logic [WIDTH-1:0] pkt [3];
        pkt[0] = 33'h100; pkt[1] = 33'h101; pkt[2] = 33'h102;
        do_reset();
        in_valid[2] = 1'b1; in_data[2] = 33'h200; in_tail[2] = 1'b1;
        in_valid[1] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            in_data[1] = pkt[f];
            in_tail[1] = (f == 2);
            #1;
            n_checks++;
            if (in_ready !== 4'b0010) begin
                n_fail++; $display("FAIL lock_ready_%0d: got %b want 0010", f, in_ready);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== pkt[f] || out_tail !== (f == 2)) begin
                n_fail++; $display("FAIL lock_out_%0d: got v=%b id=%0d data=%h want 1 1 %h", f, out_valid, out_id, out_data, pkt[f]);
            end
        end
        in_valid[1] = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL lock_release_ready: got %b want 0100", in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 33'h200) begin
            n_fail++; $display("FAIL lock_next_out: got v=%b id=%0d data=%h want 1 2 200", out_valid, out_id, out_data);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid[0] = 1'b1; in_data[0] = 33'h1234; in_tail[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b1; in_data[1] = 33'h55; in_tail[1] = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++; $display("FAIL bp_ready_%0d: got %b want 0000", c, in_ready);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 33'h1234 || out_id !== 2'd0 || out_tail !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold_%0d: got v=%b data=%h id=%0d want 1 1234 0", c, out_valid, out_data, out_id);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_resume_ready: got %b want 0010", in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 33'h55 || out_id !== 2'd1) begin
            n_fail++; $display("FAIL bp_resume_out: got v=%b data=%h id=%0d want 1 55 1", out_valid, out_data, out_id);
        end
        in_valid = '0;
        step();
        n_checks++;
        if (pkt_count !== 16'd2) begin
            n_fail++; $display("FAIL bp_count: got %0d want 2", pkt_count);
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        in_valid[3] = 1'b1; in_data[3] = 33'h300; in_tail[3] = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin
            n_fail++; $display("FAIL drop_first_ready: got %b want 1000", in_ready);
        end
        step();
        in_valid[3] = 1'b0;
        in_valid[0] = 1'b1; in_data[0] = 33'hA0; in_tail[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'b0000) begin
                n_fail++; $display("FAIL drop_ready_%0d: got %b want 0000", c, in_ready);
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle_out: got %b want 0", out_valid);
        end
        in_valid[3] = 1'b1; in_data[3] = 33'h301; in_tail[3] = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin
            n_fail++; $display("FAIL drop_owner_back: got %b want 1000", in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 33'h301 || out_tail !== 1'b1 || out_id !== 2'd3) begin
            n_fail++; $display("FAIL drop_tail_out: got v=%b data=%h t=%b id=%0d want 1 301 1 3", out_valid, out_data, out_tail, out_id);
        end
        in_valid[3] = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL drop_ch0_ready: got %b want 0001", in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 33'hA0) begin
            n_fail++; $display("FAIL drop_ch0_out: got v=%b id=%0d data=%h want 1 0 a0", out_valid, out_id, out_data);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_locked();
        do_reset();
        in_valid[2] = 1'b1; in_data[2] = 33'h250; in_tail[2] = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 33'h250) begin
            n_fail++; $display("FAIL rl_pre: got v=%b data=%h want 1 250", out_valid, out_data);
        end
        in_valid[0] = 1'b1; in_data[0] = 33'h0F0; in_tail[0] = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rl_async: got v=%b ready=%b want 0 0000", out_valid, in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rl_first_grant: got %b want 0001", in_ready);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 33'h0F0) begin
            n_fail++; $display("FAIL rl_out: got v=%b id=%0d data=%h want 1 0 f0", out_valid, out_id, out_data);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_wrap();
        do_reset();
        in_valid[0] = 1'b1; in_data[0] = 33'h77; in_tail[0] = 1'b1;
        repeat (65536) step();
        n_checks++;
        if (pkt_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_pre: got %h want ffff", pkt_count);
        end
        step();
        in_valid = '0;
        step();
        n_checks++;
        if (pkt_count !== 16'd1) begin
            n_fail++; $display("FAIL wrap_post: got %0d want 1", pkt_count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_rr_order();
        test_locked();
        test_backpressure();
        test_owner_drop();
        test_reset_locked();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
